// File: rtl/prot_uart_rx_pkg.sv
// Shared types and constants for the protocol-trigger UART receiver.
// Frame state encoding plus fixed frame geometry.
package prot_rx_pkg;

    localparam int DATA_BITS = 8;
    localparam int MIN_BAUD  = 2;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

endpackage

// File: rtl/prot_uart_rx_if.sv
// Serial line in, framed byte out, between line source and receiver.
// The receiver takes the slave side; the line driver takes master.
interface prot_uart_rx_if #(
    parameter int BAUD_W    = 16,
    parameter int DATA_BITS = prot_rx_pkg::DATA_BITS
);

    logic                 rx;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [DATA_BITS-1:0] serial_data;
    logic                 serial_vld;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output rx,
        output baud_cnt,
        input  serial_data,
        input  serial_vld,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  rx,
        input  baud_cnt,
        output serial_data,
        output serial_vld,
        output frame_err,
        output busy
    );

endinterface

// File: rtl/prot_uart_rx_sync.sv
// Two-flop synchronizer for the async RX line plus a history flop.
// Resets to 1 so a reset never looks like a start edge on an idle line.
module prot_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx_i,
    output logic rx_sync_o,
    output logic fall_edge_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    // synchronizer chain and previous-value flop for edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= rx_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rx_sync_o   = s2_q;
    assign fall_edge_o = s3_q & ~s2_q;

endmodule

// File: rtl/prot_uart_rx.sv
// 8N1 UART receiver with runtime bit period, mid-bit sampling.
// Emits one-cycle serial_vld or frame_err pulses per completed frame.
module prot_uart_rx #(
    parameter int BAUD_W    = 16,
    parameter int DATA_BITS = prot_rx_pkg::DATA_BITS
) (
    input  logic           clk,
    input  logic           rst,
    prot_uart_rx_if.slave  bus
);

    import prot_rx_pkg::*;

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic [BAUD_W-1:0] MIN_B    = BAUD_W'(MIN_BAUD);

    rx_state_t            state_q, state_d;
    logic [BAUD_W-1:0]    cnt_q, cnt_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 vld_q, vld_d;
    logic                 err_q, err_d;

    logic                 rx_sync;
    logic                 fall_edge;
    logic                 tick;
    logic [BAUD_W-1:0]    eff_baud;

    prot_rx_sync u_sync (
        .clk         (clk),
        .rst         (rst),
        .rx_i        (bus.rx),
        .rx_sync_o   (rx_sync),
        .fall_edge_o (fall_edge)
    );

    assign eff_baud = (bus.baud_cnt < MIN_B) ? MIN_B : bus.baud_cnt;
    assign tick     = (state_q != IDLE) && (cnt_q == '0);

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state: advance only on start edge or mid-bit sample ticks
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (fall_edge) state_d = START;
            START:   if (tick) state_d = rx_sync ? IDLE : DATA;
            DATA:    if (tick && idx_q == LAST_IDX) state_d = STOP;
            STOP:    if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // datapath next values: bit timer, shifter, byte and pulse capture
    always_comb begin
        cnt_d   = cnt_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        vld_d   = 1'b0;
        err_d   = 1'b0;
        if (state_q == IDLE) begin
            if (fall_edge) begin
                cnt_d  = bus.baud_cnt >> 1;
                baud_d = eff_baud;
                idx_d  = '0;
            end
        end else if (tick) begin
            cnt_d = baud_q - 1'b1;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
        if (tick) begin
            unique case (state_q)
                START: idx_d = '0;
                DATA: begin
                    shift_d = {rx_sync, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + 1'b1;
                end
                STOP: begin
                    if (rx_sync) begin
                        data_d = shift_q;
                        vld_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            baud_q  <= MIN_B;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    // outputs: registered pulses and byte, busy from state
    always_comb begin
        bus.serial_data = data_q;
        bus.serial_vld  = vld_q;
        bus.frame_err   = err_q;
        bus.busy        = (state_q != IDLE);
    end

endmodule

// File: tb/tb_prot_uart_rx.sv
// Directed bench for prot_uart_rx: framing, errors, false start,
// back-to-back frames, mid-frame reset, baud latching and clamping.
module tb_prot_uart_rx;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    prot_uart_rx_if bus ();

    prot_uart_rx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    int       vld_cnt  = 0;
    int       err_cnt  = 0;
    int       both_cnt = 0;
    int       wide_cnt = 0;
    logic [7:0] last_vld = 8'h00;
    logic     pv = 1'b0;
    logic     pe = 1'b0;

    int v0;
    int e0;

    // pulse monitor: counts vld/err pulses, overlap and over-long pulses
    always @(negedge clk) begin
        if (bus.serial_vld) begin
            vld_cnt  = vld_cnt + 1;
            last_vld = bus.serial_data;
        end
        if (bus.frame_err) err_cnt = err_cnt + 1;
        if (bus.serial_vld && bus.frame_err) both_cnt = both_cnt + 1;
        if ((bus.serial_vld && pv) || (bus.frame_err && pe))
            wide_cnt = wide_cnt + 1;
        pv = bus.serial_vld;
        pe = bus.frame_err;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bitp(input logic v, input int per);
        bus.rx = v;
        repeat (per) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic stp,
                        input int per, input logic [15:0] mid);
        bitp(1'b0, per);
        bus.baud_cnt = mid;
        for (int i = 0; i < 8; i++) bitp(b[i], per);
        bitp(stp, per);
        bus.rx = 1'b1;
    endtask

    initial begin
        rst          = 1'b1;
        bus.rx       = 1'b1;
        bus.baud_cnt = 16'd16;
        repeat (3) @(negedge clk);
        chk("rst_data", 32'(bus.serial_data), 32'h00);
        chk("rst_vld",  32'(bus.serial_vld),  32'h0);
        chk("rst_err",  32'(bus.frame_err),   32'h0);
        chk("rst_busy", 32'(bus.busy),        32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // good frame 0xAB
        v0 = vld_cnt; e0 = err_cnt;
        send(8'hAB, 1'b1, 16, 16'd16);
        repeat (4) @(negedge clk);
        chk("ab_vld_n",  32'(vld_cnt - v0),       32'd1);
        chk("ab_err_n",  32'(err_cnt - e0),       32'd0);
        chk("ab_data",   32'(bus.serial_data),    32'hAB);
        chk("ab_pulse",  32'(last_vld),           32'hAB);
        chk("ab_busy",   32'(bus.busy),           32'h0);

        // stop bit low -> frame error, data kept
        v0 = vld_cnt; e0 = err_cnt;
        send(8'h83, 1'b0, 16, 16'd16);
        repeat (4) @(negedge clk);
        chk("ferr_err_n", 32'(err_cnt - e0),      32'd1);
        chk("ferr_vld_n", 32'(vld_cnt - v0),      32'd0);
        chk("ferr_data",  32'(bus.serial_data),   32'hAB);

        // false start: 3-cycle glitch
        v0 = vld_cnt; e0 = err_cnt;
        bus.rx = 1'b0;
        repeat (3) @(negedge clk);
        bus.rx = 1'b1;
        chk("fs_busy_hi", 32'(bus.busy), 32'h1);
        repeat (10) @(negedge clk);
        chk("fs_busy_lo", 32'(bus.busy), 32'h0);
        repeat (40) @(negedge clk);
        chk("fs_vld_n", 32'(vld_cnt - v0), 32'd0);
        chk("fs_err_n", 32'(err_cnt - e0), 32'd0);

        // back-to-back at 10 clocks per bit
        bus.baud_cnt = 16'd10;
        v0 = vld_cnt; e0 = err_cnt;
        send(8'h83, 1'b1, 10, 16'd10);
        chk("b2b_first", 32'(last_vld), 32'h83);
        send(8'h11, 1'b1, 10, 16'd10);
        repeat (4) @(negedge clk);
        chk("b2b_vld_n", 32'(vld_cnt - v0), 32'd2);
        chk("b2b_last",  32'(last_vld),     32'h11);
        chk("b2b_err_n", 32'(err_cnt - e0), 32'd0);

        // reset in the middle of a data phase
        bus.baud_cnt = 16'd16;
        v0 = vld_cnt; e0 = err_cnt;
        bitp(1'b0, 16);
        bitp(1'b1, 16);
        bitp(1'b1, 16);
        chk("mr_busy_pre", 32'(bus.busy), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mr_data0", 32'(bus.serial_data), 32'h00);
        chk("mr_busy0", 32'(bus.busy),        32'h0);
        chk("mr_vld0",  32'(bus.serial_vld),  32'h0);
        repeat (200) @(negedge clk);
        chk("mr_quiet_v", 32'(vld_cnt - v0), 32'd0);
        chk("mr_quiet_e", 32'(err_cnt - e0), 32'd0);
        send(8'hBB, 1'b1, 16, 16'd16);
        repeat (4) @(negedge clk);
        chk("mr_data", 32'(bus.serial_data), 32'hBB);
        chk("mr_vld_n", 32'(vld_cnt - v0),   32'd1);

        // baud change after start bit is ignored
        v0 = vld_cnt;
        send(8'h3C, 1'b1, 16, 16'd4);
        repeat (4) @(negedge clk);
        chk("latch_data", 32'(bus.serial_data), 32'h3C);
        chk("latch_vld",  32'(vld_cnt - v0),    32'd1);

        // baud 0 and 1 clamp to 2 clocks per bit
        bus.baud_cnt = 16'd0;
        repeat (4) @(negedge clk);
        v0 = vld_cnt;
        send(8'hA5, 1'b1, 2, 16'd0);
        repeat (4) @(negedge clk);
        chk("b0_data", 32'(bus.serial_data), 32'hA5);
        chk("b0_vld",  32'(vld_cnt - v0),    32'd1);
        bus.baud_cnt = 16'd1;
        repeat (4) @(negedge clk);
        v0 = vld_cnt;
        send(8'h5A, 1'b1, 2, 16'd1);
        repeat (4) @(negedge clk);
        chk("b1_data", 32'(bus.serial_data), 32'h5A);
        chk("b1_vld",  32'(vld_cnt - v0),    32'd1);

        // held-low line: one error, then quiet
        bus.baud_cnt = 16'd16;
        repeat (4) @(negedge clk);
        v0 = vld_cnt; e0 = err_cnt;
        bitp(1'b0, 16 * 10 + 300);
        chk("hl_err_n", 32'(err_cnt - e0), 32'd1);
        chk("hl_vld_n", 32'(vld_cnt - v0), 32'd0);
        chk("hl_busy",  32'(bus.busy),     32'h0);
        bus.rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("hl_err_end", 32'(err_cnt - e0), 32'd1);
        chk("hl_data",    32'(bus.serial_data), 32'h5A);

        chk("never_both", 32'(both_cnt), 32'd0);
        chk("one_cycle",  32'(wide_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prot_uart_rx.md
Name: prot_uart_rx

Overview:
Serial receiver that feeds the protocol-trigger comparator. It recovers 8N1 UART frames from an asynchronous RX line and presents each byte as serial_data, qualified by a one-cycle serial_vld pulse. The comparator consumes this serial_data/serial_vld pair directly. The baud period is a runtime input so firmware can retarget the analyzer without resynthesis.

Parameters:
BAUD_W, 16, width of baud_cnt input and internal bit-period counter
DATA_BITS, 8, data bits per frame; serial_data width; fixed at 8 for trigger use

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
rx  input  1  asynchronous serial line, idle high
baud_cnt  input  BAUD_W  clocks per bit; values below 2 treated as 2
serial_data  output  DATA_BITS  last correctly framed byte
serial_vld  output  1  one-cycle pulse: serial_data updated this cycle
frame_err  output  1  one-cycle pulse: stop bit sampled low
busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset (rst=1 at clk edge) is synchronous: serial_data=0, serial_vld=0, frame_err=0, busy=0, state=IDLE, sync flops=1 (line treated as idle), shift reg=0. Reset mid-frame aborts the frame with no vld/err pulse.
- rx passes through a 2-flop synchronizer, then a third flop for falling-edge detect. Start is detected when prev=1 and cur=0.
- Bit timer: counter loaded at start detect with baud_cnt>>1 (floor) and decremented each cycle. At 0: sample rx_sync, reload with eff_baud-1. eff_baud = max(baud_cnt,2), latched at start detect; baud_cnt changes mid-frame are ignored.
- States:
  - IDLE: on falling edge, go to START and latch eff_baud. busy goes high the next cycle.
  - START: at mid-bit sample, rx=0 goes to DATA with bit_idx=0. rx=1 is a false start: return to IDLE with no pulse.
  - DATA: each sample shifts in MSB-side and shifts right, so the byte is LSB first. After the 8th sample, go to STOP.
  - STOP: at sample, rx=1 loads serial_data<=shift and pulses serial_vld. rx=0 pulses frame_err and leaves serial_data unchanged. Both return to IDLE.
- serial_vld and frame_err are registered and assert the cycle after the stop sample. They are never both high; each is high for exactly 1 cycle.
- After a frame error, a new start requires rx to return high first, which the edge detect enforces. A held-low line produces exactly one frame_err and then stays quiet.
- Back-to-back frames: a start edge arriving in the first IDLE cycle after the stop sample is accepted. There is no dead time beyond the edge-detect pipeline.
- serial_data holds its value between frames. Consumers qualify it with serial_vld only.

Decomposition:
- Package prot_rx_pkg: state enum typedef (IDLE, START, DATA, STOP), DATA_BITS constant, MIN_BAUD=2 constant.
- Sub-module prot_rx_sync: 2-flop synchronizer plus edge-detect flop, with reset value 1. Outputs rx_sync and fall_edge.

Test Plan:
- baud_cnt=16; send 0xAB (start, bits LSB first, stop=1) -> exactly one serial_vld pulse, serial_data=8'hAB, frame_err=0, busy low after the frame.
- baud_cnt=16; send 0x83 with stop bit=0 -> frame_err one-cycle pulse, serial_vld stays 0, serial_data keeps previous 8'hAB.
- baud_cnt=16; rx low for 3 cycles then high -> START samples 1, returns to IDLE, no vld/err, busy back to 0 within 11 cycles.
- baud_cnt=10; send 0x83 then immediately 0x11 (stop bit followed directly by next start) -> two serial_vld pulses with 8'h83 then 8'h11.
- baud_cnt=16; assert rst mid-DATA for 1 cycle, then send 0xBB -> outputs zero on the cycle after rst, no pulse from the aborted frame, next frame yields serial_data=8'hBB.
- Start a frame at baud_cnt=16, change baud_cnt to 4 after the start bit -> frame still decodes correctly (0x3C). baud_cnt=0 or 1 -> decodes at a 2-clock bit period.
